// File: rtl/bin2oht_pkg.sv
// Elaboration helpers for the pipelined binary to one-hot decoder.
// Stage k is 1-based and stage 0 is the virtual input stage (a single set bit).
package bin2oht_pkg;

   function automatic int stages(input int width, input int split);
      int wl;
      int sl;
      wl = $clog2(width);
      sl = $clog2(split);
      return (wl + sl - 1) / sl;
   endfunction

   // The last stage takes whatever index bits remain, which may be fewer than SPLIT_LOG.
   function automatic int stage_bits(input int width, input int split, input int k);
      int left;
      left = $clog2(width) - (k - 1) * $clog2(split);
      return (left < $clog2(split)) ? left : $clog2(split);
   endfunction

   function automatic int stage_width(input int width, input int split, input int k);
      int used;
      used = k * $clog2(split);
      if (used > $clog2(width)) used = $clog2(width);
      return 1 << used;
   endfunction

endpackage

// File: rtl/bin2oht_stage.sv
// One register slice of the decoder: widens the partial one-hot by 2**N using the top N
// remaining index bits, with a combinational ready pass-through for bubble collapsing.
module bin2oht_stage #(
   parameter int IW = 1,
   parameter int N  = 1,
   parameter int RW = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_vld,
   output logic                 i_rdy,
   input  logic [IW-1:0]        i_oht,
   input  logic [RW-1:0]        i_rem,
   output logic                 o_vld,
   input  logic                 o_rdy,
   output logic [(IW<<N)-1:0]   o_oht,
   output logic [RW-1:0]        o_rem
);

   localparam int OW = IW << N;

   logic          vld_q, vld_d;
   logic [OW-1:0] oht_q, oht_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [N-1:0]  sel;
   logic [OW-1:0] dec;

   // Remaining index bits are kept MSB-aligned, so each stage always decodes the top N bits.
   assign sel   = i_rem[RW-1 -: N];
   assign i_rdy = ~vld_q | o_rdy;

   always_comb begin
      dec = '0;
      for (int j = 0; j < IW; j++) begin
         for (int m = 0; m < (1 << N); m++) begin
            dec[j*(1<<N) + m] = i_oht[j] & (sel == N'(m));
         end
      end
   end

   // NOTE: every always_comb output gets a default first (hold), otherwise a latch is inferred.
   always_comb begin
      vld_d = vld_q;
      oht_d = oht_q;
      rem_d = rem_q;
      if (i_rdy) begin
         vld_d = i_vld;
         oht_d = i_vld ? dec : '0;
         rem_d = i_vld ? (i_rem << N) : '0;
      end
   end

   // NOTE: state updates use non-blocking assignments; reset here is synchronous, sampled on clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         oht_q <= '0;
         rem_q <= '0;
      end else begin
         vld_q <= vld_d;
         oht_q <= oht_d;
         rem_q <= rem_d;
      end
   end

   assign o_vld = vld_q;
   assign o_oht = oht_q;
   assign o_rem = rem_q;

endmodule

// File: rtl/bin2oht_pipe.sv
// Pipelined binary to one-hot decoder with valid/ready handshake; decodes MSB first,
// SPLIT_LOG index bits per stage, one registered stage per slice.
module bin2oht_pipe
   import bin2oht_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SPLIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_vld,
   output logic                     i_rdy,
   input  logic [$clog2(WIDTH)-1:0] i_bin,
   output logic                     o_vld,
   input  logic                     o_rdy,
   output logic [WIDTH-1:0]         o_oht
);

   localparam int WIDTH_LOG = $clog2(WIDTH);
   localparam int STAGES    = stages(WIDTH, SPLIT);

   if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("bin2oht_pipe: WIDTH must be a power of 2 and >= 2");
   end
   if (SPLIT < 2 || SPLIT > WIDTH || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
      $error("bin2oht_pipe: SPLIT must be a power of 2 within 2..WIDTH");
   end

   // Element k is the output of stage k; element 0 is the virtual input stage.
   logic                 vld_w [STAGES+1];
   logic                 rdy_w [STAGES+1];
   logic [WIDTH-1:0]     oht_w [STAGES+1];
   logic [WIDTH_LOG-1:0] rem_w [STAGES+1];

   assign vld_w[0]      = i_vld;
   assign oht_w[0]      = WIDTH'(1);
   assign rem_w[0]      = i_bin;
   assign rdy_w[STAGES] = o_rdy;
   assign i_rdy         = rdy_w[0];

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int IW = stage_width(WIDTH, SPLIT, g);
      localparam int N  = stage_bits(WIDTH, SPLIT, g + 1);
      localparam int OW = stage_width(WIDTH, SPLIT, g + 1);

      logic [OW-1:0] oht_o;

      bin2oht_stage #(
         .IW (IW),
         .N  (N),
         .RW (WIDTH_LOG)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .i_vld (vld_w[g]),
         .i_rdy (rdy_w[g]),
         .i_oht (oht_w[g][IW-1:0]),
         .i_rem (rem_w[g]),
         .o_vld (vld_w[g+1]),
         .o_rdy (rdy_w[g+1]),
         .o_oht (oht_o),
         .o_rem (rem_w[g+1])
      );

      assign oht_w[g+1] = WIDTH'(oht_o);
   end

   assign o_vld = vld_w[STAGES];
   assign o_oht = oht_w[STAGES];

endmodule

// File: tb/tb_bin2oht_pipe.sv
// Bench for bin2oht_pipe: a 16/4 instance driven through a scoreboard and a 32/4 instance
// exercising the short final stage.
module tb_bin2oht_pipe;

   typedef struct {
      logic [3:0]  bin;
      logic [15:0] exp_oht;
   } vec16_t;

   typedef struct {
      logic [4:0]  bin;
      logic [31:0] exp_oht;
   } vec32_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_i_vld, a_i_rdy, a_o_vld, a_o_rdy;
   logic [3:0]  a_i_bin;
   logic [15:0] a_o_oht;
   logic        b_i_vld, b_i_rdy, b_o_vld, b_o_rdy;
   logic [4:0]  b_i_bin;
   logic [31:0] b_o_oht;

   bin2oht_pipe #(.WIDTH(16), .SPLIT(4)) dut_a (
      .clk(clk), .rst(rst), .i_vld(a_i_vld), .i_rdy(a_i_rdy), .i_bin(a_i_bin),
      .o_vld(a_o_vld), .o_rdy(a_o_rdy), .o_oht(a_o_oht)
   );

   bin2oht_pipe #(.WIDTH(32), .SPLIT(4)) dut_b (
      .clk(clk), .rst(rst), .i_vld(b_i_vld), .i_rdy(b_i_rdy), .i_bin(b_i_bin),
      .o_vld(b_o_vld), .o_rdy(b_o_rdy), .o_oht(b_o_oht)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_pushed = 0;
   int          n_popped = 0;
   int          n_discarded = 0;
   logic [15:0] sb_q[$];
   vec16_t      stream_tbl [16];
   vec32_t      odd_tbl [4];
   logic [3:0]  bp_bin [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle on dut_a (called at a negedge), score transfers, advance to next negedge.
   task automatic cycle_a(input logic vld, input logic [3:0] bin, input logic ordy,
                          output logic acc);
      a_i_vld = vld;
      a_i_bin = bin;
      a_o_rdy = ordy;
      #1;
      acc = 1'b0;
      if (!rst) begin
         if (!a_o_vld) begin
            check("idle_zero", 32'(a_o_oht), 32'h0);
         end else if (a_o_rdy) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_underflow: actual=%h required=none", a_o_oht);
            end else begin
               check("sb_order", 32'(a_o_oht), 32'(sb_q.pop_front()));
               n_popped++;
            end
         end
         if (vld && a_i_rdy) begin
            sb_q.push_back(16'(1) << bin);
            n_pushed++;
            acc = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(input int bound);
      logic acc;
      int   c;
      c = 0;
      while (sb_q.size() != 0 && c < bound) begin
         cycle_a(1'b0, 4'bx, 1'b1, acc);
         c++;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      int   idx;

      for (int i = 0; i < 16; i++) begin
         stream_tbl[i].bin     = 4'(i);
         stream_tbl[i].exp_oht = 16'(1) << i;
      end
      odd_tbl[0] = '{5'd31, 32'h8000_0000};
      odd_tbl[1] = '{5'd0,  32'h0000_0001};
      odd_tbl[2] = '{5'd16, 32'h0001_0000};
      odd_tbl[3] = '{5'd5,  32'h0000_0020};
      bp_bin = '{4'd3, 4'd7, 4'd11, 4'd15};

      // Reset: two cycles with X index and no valid.
      rst = 1'b1;
      a_i_vld = 1'b0; a_i_bin = 'x; a_o_rdy = 1'b1;
      b_i_vld = 1'b0; b_i_bin = 'x; b_o_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_o_vld", 32'(a_o_vld), 32'd0);
      check("rst_o_oht", 32'(a_o_oht), 32'h0);
      check("rst_i_rdy", 32'(a_i_rdy), 32'd1);
      check("rst_b_o_vld", 32'(b_o_vld), 32'd0);
      rst = 1'b0;

      // Streaming 0..15 back-to-back; output follows two cycles later, continuously.
      for (int i = 0; i < 18; i++) begin
         if (i >= 2) begin
            check("stream_vld", 32'(a_o_vld), 32'd1);
            check("stream_oht", 32'(a_o_oht), 32'(stream_tbl[i-2].exp_oht));
         end
         if (i < 16) begin
            cycle_a(1'b1, stream_tbl[i].bin, 1'b1, acc);
            check("stream_acc", 32'(acc), 32'd1);
         end else begin
            cycle_a(1'b0, 4'bx, 1'b1, acc);
         end
      end
      drain(10);

      // Backpressure: 3 and 7 enter, then the full pipe stalls with 0x0008 on the output.
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (c >= 3 && c <= 7) begin
            check("bp_i_rdy", 32'(a_i_rdy), 32'd0);
            check("bp_o_vld", 32'(a_o_vld), 32'd1);
            check("bp_o_oht", 32'(a_o_oht), 32'h0008);
         end
         cycle_a(idx < 4, bp_bin[idx & 3], (c < 2 || c > 6), acc);
         if (acc) idx++;
      end
      check("bp_all_in", 32'(idx), 32'd4);
      drain(10);

      // Bubbles with random downstream stalls.
      for (int c = 0; c < 80; c++) begin
         cycle_a((c % 2) == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc);
      end
      drain(40);

      // Mid-stream reset discards a full, stalled pipe holding 5 and 6.
      cycle_a(1'b1, 4'd5, 1'b1, acc);
      cycle_a(1'b1, 4'd6, 1'b0, acc);
      cycle_a(1'b0, 4'bx, 1'b0, acc);
      check("mr_full_i_rdy", 32'(a_i_rdy), 32'd0);
      check("mr_full_oht", 32'(a_o_oht), 32'h0020);
      rst = 1'b1;
      cycle_a(1'b0, 4'bx, 1'b0, acc);
      rst = 1'b0;
      n_discarded = sb_q.size();
      sb_q.delete();
      check("mr_o_vld", 32'(a_o_vld), 32'd0);
      check("mr_o_oht", 32'(a_o_oht), 32'h0);
      check("mr_i_rdy", 32'(a_i_rdy), 32'd1);
      for (int c = 0; c < 6; c++) begin
         check("mr_no_emit", 32'(a_o_vld), 32'd0);
         cycle_a(1'b0, 4'bx, 1'b1, acc);
      end

      // Odd split: 32 wide, three stages, last stage decodes one bit.
      for (int i = 0; i < 8; i++) begin
         if (i == 1 || i == 2) check("odd_latency", 32'(b_o_vld), 32'd0);
         if (i >= 3 && i < 7) begin
            check("odd_vld", 32'(b_o_vld), 32'd1);
            check("odd_oht", b_o_oht, odd_tbl[i-3].exp_oht);
         end
         if (i == 7) check("odd_idle", b_o_oht, 32'h0);
         b_i_vld = (i < 4);
         b_i_bin = odd_tbl[i % 4].bin;
         b_o_rdy = 1'b1;
         #1;
         if (i < 4) check("odd_i_rdy", 32'(b_i_rdy), 32'd1);
         @(negedge clk);
      end

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("out_count", 32'(n_popped), 32'(n_pushed - n_discarded));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
